// File: rtl/harris_response.sv
// harris_response: five-stage pipelined Harris corner response over the
// 4x4 interior of a 6x6 pixel window, with output coordinates and frame pulse.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-high reset of valids, outputs, counters
//   window         6x6 unsigned 8-bit pixels, window[row][col], row 0 oldest
//   window_valid   window is sampled at this edge
//   response       signed 36-bit R = det - trace^2/16, held between outputs
//   corner         response > THRESH (signed), held between outputs
//   response_valid response/corner/out_col/out_row are valid this cycle
//   out_col        column index of the current output
//   out_row        window-row index of the current output
//   frame_done     pulse with the last output of a frame
module harris_response #(
    parameter int                 IMG_W  = 480,
    parameter int                 IMG_H  = 480,
    parameter logic signed [35:0] THRESH = 36'sd1000000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [0:5][0:5][7:0]     window,
    input  logic                     window_valid,
    output logic signed [35:0]       response,
    output logic                     corner,
    output logic                     response_valid,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic                     frame_done
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 6);

    function automatic logic signed [10:0] px(input logic [7:0] p);
        return $signed({3'b000, p});
    endfunction

    logic [4:0] r_vld;

    // S1: Sobel gradients at the 16 interior positions
    logic signed [10:0] w_gx [0:15];
    logic signed [10:0] w_gy [0:15];
    logic signed [10:0] r_gx [0:15];
    logic signed [10:0] r_gy [0:15];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_gx[i] = '0;
            w_gy[i] = '0;
        end
        for (int r = 1; r <= 4; r++) begin
            for (int c = 1; c <= 4; c++) begin
                w_gx[(r-1)*4 + (c-1)] =
                    (px(window[r-1][c+1])
                     + (px(window[r][c+1]) <<< 1)
                     + px(window[r+1][c+1]))
                  - (px(window[r-1][c-1])
                     + (px(window[r][c-1]) <<< 1)
                     + px(window[r+1][c-1]));
                w_gy[(r-1)*4 + (c-1)] =
                    (px(window[r+1][c-1])
                     + (px(window[r+1][c]) <<< 1)
                     + px(window[r+1][c+1]))
                  - (px(window[r-1][c-1])
                     + (px(window[r-1][c]) <<< 1)
                     + px(window[r-1][c+1]));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (window_valid) begin
            r_gx <= w_gx;
            r_gy <= w_gy;
        end
    end

    // S2: gradient products
    logic signed [21:0] r_pxx [0:15];
    logic signed [21:0] r_pyy [0:15];
    logic signed [21:0] r_pxy [0:15];

    always_ff @(posedge clk) begin
        if (r_vld[0]) begin
            for (int i = 0; i < 16; i++) begin
                r_pxx[i] <= r_gx[i] * r_gx[i];
                r_pyy[i] <= r_gy[i] * r_gy[i];
                r_pxy[i] <= r_gx[i] * r_gy[i];
            end
        end
    end

    // S3: structure tensor sums, scaled down by 256
    logic signed [25:0] w_sxx;
    logic signed [25:0] w_syy;
    logic signed [25:0] w_sxy;
    logic [16:0]        r_a;
    logic [16:0]        r_b;
    logic signed [17:0] r_c;

    always_comb begin
        w_sxx = '0;
        w_syy = '0;
        w_sxy = '0;
        for (int i = 0; i < 16; i++) begin
            w_sxx = w_sxx + r_pxx[i];
            w_syy = w_syy + r_pyy[i];
            w_sxy = w_sxy + r_pxy[i];
        end
    end

    // Sxx/Syy are non-negative; Sxy floors toward minus infinity.
    always_ff @(posedge clk) begin
        if (r_vld[1]) begin
            r_a <= 17'(w_sxx >> 8);
            r_b <= 17'(w_syy >> 8);
            r_c <= 18'(w_sxy >>> 8);
        end
    end

    // S4: tensor products
    logic [17:0]        w_t;
    logic [33:0]        r_ab;
    logic signed [35:0] r_cc;
    logic [35:0]        r_tt;

    assign w_t = 18'(r_a) + 18'(r_b);

    always_ff @(posedge clk) begin
        if (r_vld[2]) begin
            r_ab <= 34'(r_a) * 34'(r_b);
            r_cc <= 36'(r_c) * 36'(r_c);
            r_tt <= 36'(w_t) * 36'(w_t);
        end
    end

    // S5: response and threshold
    logic signed [35:0] w_r;
    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;

    assign w_r = $signed({2'b00, r_ab}) - r_cc - $signed(r_tt >> 4);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld    <= '0;
            response <= '0;
            corner   <= 1'b0;
            r_col    <= '0;
            r_row    <= '0;
        end else begin
            r_vld <= {r_vld[3:0], window_valid};
            if (r_vld[3]) begin
                response <= w_r;
                corner   <= (w_r > THRESH);
            end
            // Counters show the current output's coordinate, then advance.
            if (r_vld[4]) begin
                if (r_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign response_valid = r_vld[4];
    assign out_col        = r_col;
    assign out_row        = r_row;
    assign frame_done     = r_vld[4] & (r_col == COL_LAST)
                                     & (r_row == ROW_LAST);

endmodule

// File: tb/tb_harris_response.sv
// tb_harris_response: scoreboard bench for harris_response with an
// arithmetic reference model, random windows, bubbles and async reset.
module tb_harris_response;
    localparam int W = 8;
    localparam int H = 8;
    localparam logic signed [35:0] TH1 = 36'sd1000000;
    localparam logic signed [35:0] TH2 = -36'sd20000;

    typedef logic [0:5][0:5][7:0] win_t;

    typedef struct {
        longint r;
        bit     c1;
        bit     c2;
        int     col;
        int     row;
        bit     fd;
        int     stamp;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    win_t window = '0;
    logic window_valid = 1'b0;
    logic signed [35:0] response, response2;
    logic corner, corner2, rv, rv2, fd, fd2;
    logic [2:0] col, row, col2, row2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nout = 0;
    longint hold_r = 0;
    bit hold_c = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    harris_response #(.IMG_W(W), .IMG_H(H), .THRESH(TH1)) dut (
        .clk(clk), .reset(reset), .window(window),
        .window_valid(window_valid), .response(response),
        .corner(corner), .response_valid(rv), .out_col(col),
        .out_row(row), .frame_done(fd)
    );

    harris_response #(.IMG_W(W), .IMG_H(H), .THRESH(TH2)) dut2 (
        .clk(clk), .reset(reset), .window(window),
        .window_valid(window_valid), .response(response2),
        .corner(corner2), .response_valid(rv2), .out_col(col2),
        .out_row(row2), .frame_done(fd2)
    );

    task automatic chk(input string nm, input longint got,
                       input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic longint model_r(input win_t w);
        longint sxx = 0;
        longint syy = 0;
        longint sxy = 0;
        longint a, b, c, t, gx, gy;
        longint p [0:5][0:5];
        for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++)
                p[i][j] = longint'(w[i][j]);
        for (int r = 1; r <= 4; r++) begin
            for (int k = 1; k <= 4; k++) begin
                gx = (p[r-1][k+1] + 2*p[r][k+1] + p[r+1][k+1])
                   - (p[r-1][k-1] + 2*p[r][k-1] + p[r+1][k-1]);
                gy = (p[r+1][k-1] + 2*p[r+1][k] + p[r+1][k+1])
                   - (p[r-1][k-1] + 2*p[r-1][k] + p[r-1][k+1]);
                sxx += gx * gx;
                syy += gy * gy;
                sxy += gx * gy;
            end
        end
        a = sxx / 256;
        b = syy / 256;
        c = sxy >>> 8;
        t = a + b;
        return a * b - c * c - (t * t) / 16;
    endfunction

    function automatic win_t rand_win(input int mode);
        win_t w;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                case (mode)
                    0: w[i][j] = 8'($urandom);
                    1: w[i][j] = ($urandom_range(0, 1) != 0) ? 8'hff : 8'h00;
                    default: w[i][j] = 8'($urandom_range(90, 110));
                endcase
            end
        end
        return w;
    endfunction

    task automatic send(input win_t w, input bit v);
        exp_t e;
        @(posedge clk);
        #1;
        window_valid = v;
        window = v ? w : rand_win(0);
        if (v) begin
            e.r = model_r(w);
            e.c1 = (e.r > TH1);
            e.c2 = (e.r > TH2);
            e.col = nout % W;
            e.row = (nout / W) % (H - 5);
            e.fd = (e.col == W - 1) && (e.row == H - 6);
            e.stamp = cyc + 5;
            nout++;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) send('0, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_valid"}, rv, 0);
        chk({tag, "_response"}, response, 0);
        chk({tag, "_corner"}, corner, 0);
        chk({tag, "_col"}, col, 0);
        chk({tag, "_row"}, row, 0);
        chk({tag, "_frame_done"}, fd, 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("valid_pair", rv2, rv);
            if (rv) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got valid=1 expected 0");
                end else begin
                    e = q.pop_front();
                    chk("response", response, e.r);
                    chk("corner", corner, e.c1);
                    chk("corner_low_thresh", corner2, e.c2);
                    chk("out_col", col, e.col);
                    chk("out_row", row, e.row);
                    chk("frame_done", fd, e.fd);
                    chk("latency", cyc, e.stamp);
                    hold_r = e.r;
                    hold_c = e.c1;
                end
            end else begin
                chk("hold_response", response, hold_r);
                chk("hold_corner", corner, hold_c);
                chk("frame_done_idle", fd, 0);
            end
        end
    end

    initial begin
        win_t flat, step, single;
        int guard;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 6; j++) begin
                flat[i][j] = 8'd100;
                step[i][j] = (j < 3) ? 8'd0 : 8'd255;
                single[i][j] = 8'd0;
            end
        end
        single[0][0] = 8'd255;

        #2;
        chk_reset_state("init");
        @(negedge clk);
        #2 reset = 1'b0;

        send(flat, 1'b1);
        idle(6);
        send(step, 1'b1);
        idle(6);
        send(single, 1'b1);
        idle(6);

        send(rand_win(0), 1'b1);
        send(rand_win(0), 1'b0);
        send(rand_win(0), 1'b0);
        send(rand_win(1), 1'b1);
        send(rand_win(0), 1'b1);
        idle(7);

        for (int n = 0; n < 150; n++)
            send(rand_win($urandom_range(0, 2)),
                 $urandom_range(0, 3) != 0);

        send(rand_win(0), 1'b1);
        send(rand_win(1), 1'b1);
        send(rand_win(0), 1'b1);
        @(posedge clk);
        #1 window_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk_reset_state("async_reset");
        q.delete();
        nout = 0;
        hold_r = 0;
        hold_c = 0;
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        idle(8);

        send(single, 1'b1);
        idle(8);
        for (int n = 0; n < 26; n++)
            send(rand_win($urandom_range(0, 2)), 1'b1);
        for (int n = 0; n < 40; n++)
            send(rand_win($urandom_range(0, 2)),
                 $urandom_range(0, 1) != 0);
        idle(1);

        guard = 0;
        while (q.size() != 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
